ps2_key_receiver: RTL
=====================

// Module: ps2_key_receiver
// PURPOSE
//  Deserialises PS/2 keyboard frames on PS2Clk/PS2Data into key events (scan code + make/break + extended flags).
//  Sits between the board PS/2 pins and the PlayerPianoRamp note/command decoder.
//  Absorbs the F0 (break) and E0 (extended) prefixes.
//  Presents one event at a time on a valid/ack handshake.
// PARAMETERS
//  FILTER_LEN      8        Clock cycles PS2Clk must be stable before a level change is accepted (glitch filter).
//  TIMEOUT_CYCLES  200000   Cycles with no PS2Clk falling edge inside a frame before the frame is abandoned (2 ms at 100 MHz).
// PORTS
//  Clock         in   1  system clock; all logic on its rising edge
//  btnCpuReset   in   1  synchronous, active-low reset
//  PS2Clk        in   1  asynchronous keyboard clock; idle high
//  PS2Data       in   1  asynchronous keyboard data; idle high
//  key_code      out  8  scan code of the held event (prefixes stripped)
//  key_release   out  1  held event was preceded by F0 (key up)
//  key_extended  out  1  held event was preceded by E0
//  key_valid     out  1  event held in output register; stays high until accepted
//  key_ack       in   1  consumer accepts the event in a cycle where key_valid=1
//  frame_error   out  1  1-cycle pulse: parity error, stop bit 0, or timeout
//  overflow      out  1  1-cycle pulse: an event was dropped because key_valid=1 and key_ack=0
// BEHAVIOUR
//  Reset (btnCpuReset=0 at a Clock edge):
//   - all outputs 0; FSM to IDLE; bit counter, shift register, prefix flags and timeout counter cleared.
//   - synchronisers/filter preset to 1 (idle).
//   - reset mid-frame discards the partial frame; any misframe from the rest of that frame is recovered by the stop/parity check or by the timeout.
//  Input path:
//   - 2-FF synchroniser on both pins.
//   - PS2Clk filtered: the filtered level changes only after FILTER_LEN consecutive equal synchronised samples.
//   - fall = 1-cycle pulse on a filtered 1->0 transition. Data is sampled from synchronised PS2Data on fall only.
//  Frame:
//   - 11 bits, LSB first: start(0), d0..d7, odd parity, stop(1).
//  FSM (advances only on fall, except timeout):
//   - IDLE:   on fall with data=0, go to DATA with cnt=0; data=1 is ignored and FSM stays in IDLE.
//   - DATA:   shift bit into sr[7] (right shift); cnt++; after the 8th bit, go to PARITY.
//   - PARITY: store p; go to STOP.
//   - STOP:   on fall, check data==1 and ^{sr,p}==1.
//       - Pass: go to DECODE.
//       - Fail: pulse frame_error, clear prefix flags, go to IDLE.
//   - DECODE (one cycle, no fall needed), then IDLE:
//       - sr==8'hF0: set brk.
//       - sr==8'hE0: set ext.
//       - otherwise: emit an event {sr, brk, ext}, then clear brk and ext.
//  Timeout:
//   - counter runs in DATA/PARITY/STOP and is cleared on every fall.
//   - reaching TIMEOUT_CYCLES-1: pulse frame_error, clear prefixes, go to IDLE.
//  Output handshake (1-deep register):
//   - Emit when key_valid=0, or when key_valid=1 and key_ack=1 in the same cycle: load register, key_valid=1 next cycle.
//   - Emit when key_valid=1 and key_ack=0: new event dropped, held event kept, overflow pulses.
//   - key_ack with no emit: key_valid goes to 0 next cycle.
//   - key_ack while key_valid=0: ignored.
//  Latency: key_valid rises 2 cycles after the fall that samples the stop bit (DECODE + register).
// STRUCTURE
//  Package ps2_pkg: FSM state enum (IDLE, DATA, PARITY, STOP, DECODE); constants PS2_BREAK=8'hF0, PS2_EXT=8'hE0, PS2_DATA_BITS=8.
//  Sub-module ps2_input_filter:
//   - synchronisers + PS2Clk glitch filter.
//   - outputs fall and the synchronised data bit; reused by any later PS/2 consumer.
//  Top: FSM, shift/parity, timeout counter, prefix flags, output register.
// TESTING (10 us PS/2 bit period, 100 us between frames)
//  1. Frame 0x16 (bits 0,0,1,1,0,1,0,0,0,0,1) -> key_valid=1, key_code=8'h16, release=0, ext=0; ack -> key_valid=0 next cycle.
//  2. F0 then 0x15 -> exactly one event: key_code=8'h15, key_release=1; a following 0x16 -> key_release=0 (flags cleared).
//  3. E0,F0,5A -> one event: key_code=8'h5A, release=1, ext=1.
//  4. 0x16 with parity bit flipped -> frame_error pulse, no key_valid; next good 0x15 -> key_code=8'h15, release=0.
//  5. Two 0x16 frames, no ack -> first event held, overflow pulses once; ack in the same cycle as an emit -> no overflow, key_valid stays 1.
//  6. Mid-frame faults:
//     - stop after 5 bits -> frame_error after TIMEOUT_CYCLES, then a clean 0x16 decodes.
//     - 3-cycle PS2Clk glitch -> no bit sampled.
//     - reset mid-frame -> all outputs 0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types and constants.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    DECODE
  } ps2_state_t;

  localparam logic [7:0]  PS2_BREAK     = 8'hF0;
  localparam logic [7:0]  PS2_EXT       = 8'hE0;
  localparam int unsigned PS2_DATA_BITS = 8;

endpackage

// File: rtl/ps2_key_receiver_if.sv
// Key-event handshake between the PS/2 receiver and its consumer.
interface ps2_key_receiver_if;

  logic [7:0] key_code;
  logic       key_release;
  logic       key_extended;
  logic       key_valid;
  logic       key_ack;
  logic       frame_error;
  logic       overflow;

  modport master (
    output key_code, key_release, key_extended, key_valid, frame_error, overflow,
    input  key_ack
  );

  modport slave (
    input  key_code, key_release, key_extended, key_valid, frame_error, overflow,
    output key_ack
  );

endinterface

// File: rtl/ps2_input_filter.sv
// PS/2 pin synchronisers plus PS2Clk glitch filter; emits a one-cycle fall pulse.
module ps2_input_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [1:0]       clk_sync;
  logic [1:0]       data_sync;
  logic             clk_filt;
  logic [CNT_W-1:0] stable_cnt;

  // stable_cnt counts consecutive synchronised samples that disagree with the filtered level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sync   <= '1;
      data_sync  <= '1;
      clk_filt   <= 1'b1;
      stable_cnt <= '0;
      fall       <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      fall      <= 1'b0;
      if (clk_sync[1] == clk_filt) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        clk_filt   <= clk_sync[1];
        stable_cnt <= '0;
        fall       <= clk_filt;
      end else begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
    end
  end

  assign data = data_sync[1];

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard frame receiver: strips F0/E0 prefixes and presents key events on a valid/ack register.
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic                       Clock,
  input  logic                       btnCpuReset,
  input  logic                       PS2Clk,
  input  logic                       PS2Data,
  ps2_key_receiver_if.master         key
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  ps2_state_t       state, state_next;
  logic             fall, data;
  logic [2:0]       bit_cnt;
  logic [7:0]       sr;
  logic             par;
  logic [TMO_W-1:0] tmo_cnt;
  logic             brk, ext;
  logic             in_frame, timeout, stop_ok, emit, frame_err;

  ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk      (Clock),
    .rst_n    (btnCpuReset),
    .ps2_clk  (PS2Clk),
    .ps2_data (PS2Data),
    .fall     (fall),
    .data     (data)
  );

  always_ff @(posedge Clock) begin
    if (!btnCpuReset) state <= IDLE;
    else              state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (fall && !data) state_next = DATA;
      DATA:   if (timeout) state_next = IDLE;
              else if (fall && bit_cnt == 3'(PS2_DATA_BITS - 1)) state_next = PARITY;
      PARITY: if (timeout) state_next = IDLE;
              else if (fall) state_next = STOP;
      STOP:   if (timeout) state_next = IDLE;
              else if (fall) state_next = stop_ok ? DECODE : IDLE;
      DECODE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A fall on the last timeout cycle wins: the frame is still alive.
  always_comb begin
    in_frame  = (state == DATA) || (state == PARITY) || (state == STOP);
    timeout   = in_frame && !fall && (tmo_cnt == TMO_LAST);
    stop_ok   = data && (^{sr, par});
    frame_err = timeout || (state == STOP && fall && !stop_ok);
    emit      = (state == DECODE) && (sr != PS2_BREAK) && (sr != PS2_EXT);
  end

  always_ff @(posedge Clock) begin
    if (!btnCpuReset) begin
      bit_cnt          <= '0;
      sr               <= '0;
      par              <= 1'b0;
      tmo_cnt          <= '0;
      brk              <= 1'b0;
      ext              <= 1'b0;
      key.key_code     <= '0;
      key.key_release  <= 1'b0;
      key.key_extended <= 1'b0;
      key.key_valid    <= 1'b0;
      key.frame_error  <= 1'b0;
      key.overflow     <= 1'b0;
    end else begin
      if (state == IDLE && fall && !data) bit_cnt <= '0;
      else if (state == DATA && fall)     bit_cnt <= bit_cnt + 3'd1;

      if (state == DATA && fall)   sr  <= {data, sr[7:1]};
      if (state == PARITY && fall) par <= data;

      if (!in_frame || fall) tmo_cnt <= '0;
      else                   tmo_cnt <= tmo_cnt + TMO_W'(1);

      if (frame_err) begin
        brk <= 1'b0;
        ext <= 1'b0;
      end else if (state == DECODE) begin
        if (sr == PS2_BREAK)    brk <= 1'b1;
        else if (sr == PS2_EXT) ext <= 1'b1;
        else begin
          brk <= 1'b0;
          ext <= 1'b0;
        end
      end

      key.frame_error <= frame_err;
      key.overflow    <= emit && key.key_valid && !key.key_ack;

      if (emit && (!key.key_valid || key.key_ack)) begin
        key.key_code     <= sr;
        key.key_release  <= brk;
        key.key_extended <= ext;
        key.key_valid    <= 1'b1;
      end else if (key.key_valid && key.key_ack) begin
        key.key_valid <= 1'b0;
      end
    end
  end

endmodule
